iterative_divider: RTL and testbench

- Multi-cycle RV32M divide/remainder unit. It is the inverse-operation counterpart of the execute-stage Booth multiplier.
- Sits beside the multiplier in EXU and uses the same valid/ready stage handshake: slave on the request side, master on the result side.
- Computes DIV, DIVU, REM and REMU with a 32-iteration restoring algorithm on magnitudes, followed by a sign fix-up.
- Divide-by-zero and signed overflow are resolved without iterating.

---
 rtl/iterative_divider.sv | 174 +++++++++++++++++
 tb/tb_iterative_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Restoring division on operand magnitudes, one quotient bit per cycle,
// followed by a sign fix-up. Divide-by-zero and signed overflow finish
// without iterating.
// Build option: DIV_EARLY_EXIT_EN - when defined, a dividend whose magnitude
// is below the divisor magnitude finishes straight from S_PREP.
module iterative_divider #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ITER_CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_dataA,
   input  logic [XLEN-1:0] in_dataB,
   input  logic [1:0]      in_opcode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_DONE
   } state_t;

   state_t state_q, state_nx;

   logic [XLEN-1:0]       a_q, b_q;
   logic [1:0]            op_q;
   logic [XLEN-1:0]       mag_b_q;
   // Partial remainder is kept XLEN wide: after each restore step it is
   // below |B|, so its 33rd bit is always zero. The trial subtract is 33 bits.
   logic [XLEN-1:0]       rem_q;
   logic [XLEN-1:0]       quo_q;
   logic [ITER_CNT_W-1:0] cnt_q;
   logic                  q_neg_q, r_neg_q;
   logic [XLEN-1:0]       result_q;

   logic                  is_signed, is_rem;
   logic                  sign_a, sign_b;
   logic [XLEN-1:0]       abs_a, abs_b;
   logic                  b_zero, ovf, early;
   logic [XLEN-1:0]       prep_result;
   logic [XLEN:0]         rem_sh, trial;
   logic [XLEN-1:0]       rem_nx, quo_nx;
   logic [XLEN-1:0]       quo_fix, rem_fix;
   logic                  last_iter;

   // Operand preparation, iteration step and sign fix-up datapath
   always_comb begin
      is_signed   = ~op_q[0];
      is_rem      = op_q[1];
      sign_a      = is_signed & a_q[XLEN-1];
      sign_b      = is_signed & b_q[XLEN-1];
      abs_a       = sign_a ? ('0 - a_q) : a_q;
      abs_b       = sign_b ? ('0 - b_q) : b_q;
      b_zero      = (b_q == '0);
      ovf         = is_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
`ifdef DIV_EARLY_EXIT_EN
      early       = !b_zero && (abs_a < abs_b);
`else
      early       = 1'b0;
`endif
      prep_result = '0;
      if (b_zero)
         prep_result = is_rem ? a_q : '1;
      else if (ovf)
         prep_result = is_rem ? '0 : a_q;
      else if (early)
         prep_result = is_rem ? a_q : '0;

      rem_sh = {rem_q, quo_q[XLEN-1]};
      trial  = rem_sh - {1'b0, mag_b_q};
      if (!trial[XLEN]) begin
         rem_nx = trial[XLEN-1:0];
         quo_nx = {quo_q[XLEN-2:0], 1'b1};
      end else begin
         rem_nx = rem_sh[XLEN-1:0];
         quo_nx = {quo_q[XLEN-2:0], 1'b0};
      end
      quo_fix   = q_neg_q ? ('0 - quo_nx) : quo_nx;
      rem_fix   = r_neg_q ? ('0 - rem_nx) : rem_nx;
      last_iter = (cnt_q == ITER_CNT_W'(1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_nx;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx  = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = !rst;
            if (in_valid)
               state_nx = S_PREP;
         end
         S_PREP: begin
            if (b_zero || ovf || early)
               state_nx = S_DONE;
            else
               state_nx = S_CALC;
         end
         S_CALC: begin
            if (last_iter)
               state_nx = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand latch, iteration registers and result register
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         mag_b_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_q  <= in_dataA;
                  b_q  <= in_dataB;
                  op_q <= in_opcode;
               end
            end
            S_PREP: begin
               rem_q   <= '0;
               quo_q   <= abs_a;
               mag_b_q <= abs_b;
               cnt_q   <= ITER_CNT_W'(XLEN);
               q_neg_q <= sign_a ^ sign_b;
               r_neg_q <= sign_a;
               if (b_zero || ovf || early)
                  result_q <= prep_result;
            end
            S_CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q - ITER_CNT_W'(1);
               if (last_iter)
                  result_q <= is_rem ? rem_fix : quo_fix;
            end
            default: ;
         endcase
      end
   end

   assign out_result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed self-checking bench for iterative_divider.
// Latency is counted in clock edges from the accepting edge to the edge at
// which out_valid is first seen high (sampled on the falling edge).
module tb_iterative_divider;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_EXIT_EN
   localparam int SMALL_LAT = 2;
`else
   localparam int SMALL_LAT = 34;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_dataA = '0;
   logic [31:0] in_dataB = '0;
   logic [1:0]  in_opcode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;

   int tests = 0;
   int fails = 0;

   iterative_divider #(.XLEN(32), .ITER_CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dataA   (in_dataA),
      .in_dataB   (in_dataB),
      .in_opcode  (in_opcode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   always #5 clk = ~clk;

   // Offer a request and return at the falling edge after it was accepted.
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      in_opcode = op;
      in_dataA  = a;
      in_dataB  = b;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!in_ready) begin
         fails++;
         $display("FAIL send_accept in_ready=%b required=1 after %0d cycles", in_ready, n);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for the result, then complete the output handshake.
   task automatic collect(output logic [31:0] res, output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         res = 'x;
         lat = -1;
      end else begin
         res = out_result;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++;
      if (out_result !== 32'h0) begin fails++; $display("FAIL reset_out_result got %h exp 00000000", out_result); end
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_arith();
      vec_t v [15];
      logic [31:0] res;
      int lat;
      v = '{
         '{OP_DIV,  32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 34},
         '{OP_REM,  32'd20,        32'hFFFFFFFD, 32'h00000002, 34},
         '{OP_DIVU, 32'hFFFFFFFF,  32'd2,        32'h7FFFFFFF, 34},
         '{OP_REMU, 32'hFFFFFFFF,  32'd2,        32'h00000001, 34},
         '{OP_DIV,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34},
         '{OP_REM,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34},
         '{OP_DIV,  32'h12345678,  32'd0,        32'hFFFFFFFF, 2},
         '{OP_REM,  32'h12345678,  32'd0,        32'h12345678, 2},
         '{OP_REMU, 32'd5,         32'd0,        32'h00000005, 2},
         '{OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 2},
         '{OP_REM,  32'h80000000,  32'hFFFFFFFF, 32'h00000000, 2},
         '{OP_DIVU, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, SMALL_LAT},
         '{OP_DIV,  32'd5,         32'd7,        32'h00000000, SMALL_LAT},
         '{OP_REM,  32'hFFFFFFFB,  32'd7,        32'hFFFFFFFB, SMALL_LAT},
         '{OP_DIVU, 32'd1000,      32'd10,       32'd100,      34}
      };
      for (int i = 0; i < 15; i++) begin
         send(v[i].op, v[i].a, v[i].b);
         collect(res, lat);
         tests++;
         if (res !== v[i].exp) begin
            fails++;
            $display("FAIL arith_result[%0d] op=%b a=%h b=%h got %h exp %h", i, v[i].op, v[i].a, v[i].b, res, v[i].exp);
         end
         tests++;
         if (lat != v[i].lat) begin
            fails++;
            $display("FAIL arith_latency[%0d] got %0d exp %0d", i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      int lat;
      send(OP_DIV, 32'd20, 32'hFFFFFFFD);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      tests++;
      if (lat != 34) begin fails++; $display("FAIL bp_latency got %0d exp 34", lat); end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d] got %b exp 1", i, out_valid); end
         tests++;
         if (out_result !== 32'hFFFFFFFA) begin fails++; $display("FAIL bp_out_result[%0d] got %h exp fffffffa", i, out_result); end
         tests++;
         if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_opcode = OP_DIVU;
      in_dataA  = 32'd100;
      in_dataB  = 32'd7;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_no_overlap in_ready got %b exp 0", in_ready); end
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop got %b exp 0", out_valid); end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_next_accept in_ready got %b exp 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      collect(res, lat);
      tests++;
      if (res !== 32'd14) begin fails++; $display("FAIL bp_next_result got %h exp 0000000e", res); end
      tests++;
      if (lat != 34) begin fails++; $display("FAIL bp_next_latency got %0d exp 34", lat); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] res;
      int lat;
      send(OP_DIV, 32'h7FFFFFFF, 32'd3);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
      tests++;
      if (out_result !== 32'h0) begin fails++; $display("FAIL midrst_out_result got %h exp 00000000", out_result); end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready_after got %b exp 1", in_ready); end
      send(OP_DIVU, 32'd100, 32'd7);
      collect(res, lat);
      tests++;
      if (res !== 32'd14) begin fails++; $display("FAIL midrst_fresh_result got %h exp 0000000e", res); end
      tests++;
      if (lat != 34) begin fails++; $display("FAIL midrst_fresh_latency got %0d exp 34", lat); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
